la_ram_write_arbiter: RTL and testbench
=======================================

Name: la_ram_write_arbiter

Overview:
- Sits inside the memory subsystem, directly upstream of the DDR3 controller user (app) interface.
- Arbitrates the two logic-analyzer pod write streams (la0, la1) onto a single write-only command/data port.
- Uses round-robin grant with a bounded burst length, so neither pod can starve the other.
- Gates all traffic until DRAM calibration completes.

Parameters:
- ADDR_WIDTH, 29: client and app address width.
- DATA_WIDTH, 128: client and app write data width.
- MAX_BURST, 16: maximum beats per grant before forced re-arbitration (≥1).

Ports:
- clk_ram  in  1  controller user clock; all logic on this clock.
- rst  in  1  synchronous active-high reset.
- ram_ready  in  1  DDR calibration complete.
- la0_wr_en  in  1  client 0 session request (held high while it has data to write).
- la0_wr_valid  in  1  client 0 addr/data valid this cycle.
- la0_wr_addr  in  ADDR_WIDTH  client 0 beat address.
- la0_wr_data  in  DATA_WIDTH  client 0 beat data.
- la0_wr_ack  out  1  client 0 beat accepted this cycle.
- la1_wr_en / la1_wr_valid / la1_wr_addr / la1_wr_data / la1_wr_ack: same as la0, for client 1.
- app_en  out  1  command valid.
- app_cmd  out  3  command; always CMD_WRITE.
- app_addr  out  ADDR_WIDTH  command address.
- app_rdy  in  1  command accepted when app_en&&app_rdy.
- app_wdf_wren  out  1  write data valid.
- app_wdf_data  out  DATA_WIDTH  write data.
- app_wdf_end  out  1  last data beat; equals app_wdf_wren (single-beat payload).
- app_wdf_rdy  in  1  data accepted when app_wdf_wren&&app_wdf_rdy.
- grant_id  out  1  client currently granted (debug).
- busy  out  1  a client is granted.

Behaviour:
- Client contract:
  - A beat transfers on a cycle where wr_valid && wr_ack.
  - The client holds addr/data/valid stable until ack.
  - wr_ack is a single-cycle pulse, combinational from app_rdy/app_wdf_rdy.
- Reset values:
  - Outputs: all 0; app_cmd=CMD_WRITE.
  - State IDLE, last_grant=1 (so client 0 wins first tie), beat_cnt=0, cmd_done=data_done=0.
- FSM states: IDLE, GRANTED.
- IDLE:
  - No grant is issued while ram_ready=0.
  - Otherwise, if exactly one la*_wr_en is high, grant that client.
  - If both are high, grant the client ≠ last_grant.
  - The transition to GRANTED takes 1 cycle; no app traffic is issued in IDLE.
- GRANTED (client g):
  - app_en = g.valid && !cmd_done.
  - app_wdf_wren = g.valid && !data_done.
  - app_addr/app_wdf_data are muxed from client g.
  - cmd_fire = app_en&&app_rdy; data_fire = app_wdf_wren&&app_wdf_rdy.
  - Beat complete when (cmd_done||cmd_fire) && (data_done||data_fire). On completion: g.ack=1 that cycle, clear both flags, beat_cnt++.
  - Partial acceptance: set the corresponding done flag; that half is not reissued.
  - Command and data may be accepted in either order or in the same cycle.
- Release to IDLE (last_grant←g, beat_cnt←0) on either:
  - beat completes with beat_cnt==MAX_BURST-1;
  - g.wr_en low with no beat half-issued (cmd_done=data_done=0).
- A half-issued beat always completes before release, even if wr_en drops or ram_ready falls.
- Round-robin rule: after release, if the other client requests it wins next; otherwise the same client is re-granted, with a 1-cycle IDLE bubble between grants.
- The non-granted client's ack stays 0.
- ram_ready falling mid-grant: finish any half-issued beat, then return to IDLE.
- Reset mid-operation: immediate return to reset values; a partially issued beat is abandoned. The controller is reset concurrently.
- beat_cnt width is $clog2(MAX_BURST)+1. No wrap occurs because the compare happens before increment.

Decomposition:
- Package sniffer_mem_pkg holds:
  - CMD_WRITE=3'b000 and CMD_READ=3'b001;
  - enum arb_state_t {ARB_IDLE, ARB_GRANTED};
  - la_wr_req_t struct (en, valid, addr, data).
- No sub-module: the two-input round-robin is inline.

Test Plan:
- ram_ready=0, both wr_en/valid high for 50 cycles -> app_en/app_wdf_wren/acks stay 0; after ram_ready=1, first grant is la0 (grant_id=0).
- la0 only, app_rdy=app_wdf_rdy=1, 20 beats, MAX_BURST=16 -> 16 acks, 1-cycle bubble, re-grant la0, 4 more acks; addr/data on app match in order.
- Both clients streaming continuously -> grants alternate 0,1,0,1, each exactly 16 beats; per-client beat totals differ by ≤16.
- app_rdy=1 with app_wdf_rdy=0 for 5 cycles, then 1 -> app_en high for 1 cycle only; ack on the cycle data is accepted; exactly one command and one data beat issued.
- Data accepted first (app_rdy=0 for 3 cycles) -> app_wdf_wren drops after 1 cycle; ack when app_rdy rises; la0_wr_en deassert mid-half-beat -> beat still completes, then IDLE.
- rst asserted while cmd_done=1 -> next cycle all outputs 0, busy=0, state IDLE, last_grant=1.

Source files
------------

// File: rtl/sniffer_mem_pkg.sv
// Shared types and constants for the sniffer memory subsystem (DDR3 app-interface side).
package sniffer_mem_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int unsigned LA_ADDR_WIDTH = 29;
    localparam int unsigned LA_DATA_WIDTH = 128;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANTED
    } arb_state_t;

    typedef struct packed {
        logic                     en;
        logic                     valid;
        logic [LA_ADDR_WIDTH-1:0] addr;
        logic [LA_DATA_WIDTH-1:0] data;
    } la_wr_req_t;

endpackage

// File: rtl/la_ram_write_arbiter.sv
// Round-robin, burst-bounded arbiter merging two logic-analyzer write streams
// onto the DDR3 controller write-only app port, held off until calibration.
module la_ram_write_arbiter
    import sniffer_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = LA_DATA_WIDTH,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk_ram,
    input  logic                  rst,
    input  logic                  ram_ready,
    input  logic                  la0_wr_en,
    input  logic                  la0_wr_valid,
    input  logic [ADDR_WIDTH-1:0] la0_wr_addr,
    input  logic [DATA_WIDTH-1:0] la0_wr_data,
    output logic                  la0_wr_ack,
    input  logic                  la1_wr_en,
    input  logic                  la1_wr_valid,
    input  logic [ADDR_WIDTH-1:0] la1_wr_addr,
    input  logic [DATA_WIDTH-1:0] la1_wr_data,
    output logic                  la1_wr_ack,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    input  logic                  app_rdy,
    output logic                  app_wdf_wren,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    output logic                  grant_id,
    output logic                  busy
);

    localparam int unsigned BCW = $clog2(MAX_BURST) + 1;

    arb_state_t     state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_grant_q, last_grant_d;
    logic           busy_q, busy_d;
    logic           cmd_done_q, cmd_done_d;
    logic           data_done_q, data_done_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    la_wr_req_t req0, req1, req_g;
    logic       granted, cmd_fire, data_fire, beat_done, last_beat, stop_req;

    // Client request bundles; the granted one drives the app port.
    always_comb begin
        req0  = '{en: la0_wr_en, valid: la0_wr_valid,
                  addr: LA_ADDR_WIDTH'(la0_wr_addr), data: LA_DATA_WIDTH'(la0_wr_data)};
        req1  = '{en: la1_wr_en, valid: la1_wr_valid,
                  addr: LA_ADDR_WIDTH'(la1_wr_addr), data: LA_DATA_WIDTH'(la1_wr_data)};
        req_g = grant_q ? req1 : req0;
    end

    // App-port handshakes; command and data halves are tracked independently.
    always_comb begin
        granted      = (state_q == ARB_GRANTED);
        app_cmd      = CMD_WRITE;
        app_addr     = ADDR_WIDTH'(req_g.addr);
        app_wdf_data = DATA_WIDTH'(req_g.data);
        app_en       = granted && req_g.valid && !cmd_done_q;
        app_wdf_wren = granted && req_g.valid && !data_done_q;
        app_wdf_end  = app_wdf_wren;
        cmd_fire     = app_en && app_rdy;
        data_fire    = app_wdf_wren && app_wdf_rdy;
        beat_done    = granted && (cmd_done_q || cmd_fire) && (data_done_q || data_fire);
        la0_wr_ack   = beat_done && !grant_q;
        la1_wr_ack   = beat_done && grant_q;
        grant_id     = grant_q;
        busy         = busy_q;
    end

    // Next-state: grant selection, beat counting and release.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        beat_cnt_d   = beat_cnt_q;
        cmd_done_d   = beat_done ? 1'b0 : (cmd_done_q || cmd_fire);
        data_done_d  = beat_done ? 1'b0 : (data_done_q || data_fire);
        last_beat    = beat_done && (beat_cnt_q == BCW'(MAX_BURST - 1));
        // Release only when no half-issued beat would be left behind.
        stop_req     = (!req_g.en || !ram_ready) && !cmd_done_d && !data_done_d;

        unique case (state_q)
            ARB_IDLE: begin
                if (ram_ready && (la0_wr_en || la1_wr_en)) begin
                    state_d = ARB_GRANTED;
                    busy_d  = 1'b1;
                    grant_d = (la0_wr_en && la1_wr_en) ? !last_grant_q : la1_wr_en;
                end
            end
            ARB_GRANTED: begin
                if (beat_done) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                end
                if (last_beat || stop_req) begin
                    state_d      = ARB_IDLE;
                    busy_d       = 1'b0;
                    last_grant_d = grant_q;
                    beat_cnt_d   = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_ram) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            beat_cnt_q   <= '0;
            cmd_done_q   <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            beat_cnt_q   <= beat_cnt_d;
            cmd_done_q   <= cmd_done_d;
            data_done_q  <= data_done_d;
        end
    end

endmodule

// File: tb/tb_la_ram_write_arbiter.sv
// Directed self-checking bench for la_ram_write_arbiter.
module tb_la_ram_write_arbiter;
    import sniffer_mem_pkg::*;

    localparam int unsigned AW = 29;
    localparam int unsigned DW = 128;
    localparam int unsigned MB = 16;

    logic          clk_ram = 1'b0;
    logic          rst;
    logic          ram_ready;
    logic          la0_wr_en, la0_wr_valid, la0_wr_ack;
    logic [AW-1:0] la0_wr_addr;
    logic [DW-1:0] la0_wr_data;
    logic          la1_wr_en, la1_wr_valid, la1_wr_ack;
    logic [AW-1:0] la1_wr_addr;
    logic [DW-1:0] la1_wr_data;
    logic          app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_wdf_data;
    logic          grant_id, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int s0, s1, lim0, lim1;
    int ids [64];

    always #5 clk_ram = ~clk_ram;

    la_ram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_ram(clk_ram), .rst(rst), .ram_ready(ram_ready),
        .la0_wr_en(la0_wr_en), .la0_wr_valid(la0_wr_valid), .la0_wr_addr(la0_wr_addr),
        .la0_wr_data(la0_wr_data), .la0_wr_ack(la0_wr_ack),
        .la1_wr_en(la1_wr_en), .la1_wr_valid(la1_wr_valid), .la1_wr_addr(la1_wr_addr),
        .la1_wr_data(la1_wr_data), .la1_wr_ack(la1_wr_ack),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .grant_id(grant_id), .busy(busy)
    );

    function automatic logic [AW-1:0] exp_addr(input int c, input int n);
        return AW'(32'h0100_0000 * c + 32'h40 + n);
    endfunction

    function automatic logic [DW-1:0] exp_data(input int c, input int n);
        return {32'(32'hDA7A_0000 + c * 256 + n), 32'(n * 7 + 1), 32'(~n), 32'(c)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Stream model: each client presents beat s<c> while below its limit.
    task automatic drive();
        la0_wr_en    = (s0 < lim0);
        la0_wr_valid = (s0 < lim0);
        la0_wr_addr  = exp_addr(0, s0);
        la0_wr_data  = exp_data(0, s0);
        la1_wr_en    = (s1 < lim1);
        la1_wr_valid = (s1 < lim1);
        la1_wr_addr  = exp_addr(1, s1);
        la1_wr_data  = exp_data(1, s1);
    endtask

    task automatic rst_all();
        s0 = 0; s1 = 0; lim0 = 0; lim1 = 0;
        drive();
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; ram_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt, prev, gap, noncontig, other, n, cmd_n, dat_n, en_n, d;

        // Reset values and calibration gating
        rst_all();
        settle();
        chk("rst_app_en", 128'(app_en), 128'(0));
        chk("rst_wren", 128'(app_wdf_wren), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_grant", 128'(grant_id), 128'(0));
        chk("rst_cmd", 128'(app_cmd), 128'(CMD_WRITE));
        ram_ready = 1'b0; lim0 = 1; lim1 = 1; drive();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            settle();
            if (app_en || app_wdf_wren || la0_wr_ack || la1_wr_ack || busy) cnt++;
            tick();
        end
        chk("gate_activity", 128'(cnt), 128'(0));
        ram_ready = 1'b1;
        tick(); settle();
        chk("first_grant", 128'(grant_id), 128'(0));
        chk("first_busy", 128'(busy), 128'(1));

        // Single client, 20 beats, burst limit forces a re-grant after 16
        rst_all();
        lim0 = 20; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        prev = 0; gap = 0; noncontig = 0; other = 0;
        for (int c = 0; c < 80 && s0 < 20; c++) begin
            drive(); settle();
            if (la0_wr_ack) begin
                chk("t2_addr", 128'(app_addr), 128'(exp_addr(0, s0)));
                chk("t2_data", 128'(app_wdf_data), 128'(exp_data(0, s0)));
                if (s0 == 16) gap = c - prev;
                else if (s0 > 0 && c - prev != 1) noncontig++;
                prev = c;
                s0++;
            end
            if (la1_wr_ack || grant_id) other++;
            tick();
        end
        chk("t2_beats", 128'(s0), 128'(20));
        chk("t2_gap", 128'(gap), 128'(2));
        chk("t2_contig", 128'(noncontig), 128'(0));
        chk("t2_other", 128'(other), 128'(0));
        drive(); tick(); settle();
        chk("t2_release", 128'(busy), 128'(0));

        // Both clients streaming: 16-beat grants alternate starting with la0
        rst_all();
        lim0 = 1000; lim1 = 1000; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        n = 0;
        for (int c = 0; c < 300 && n < 64; c++) begin
            drive(); settle();
            if (la0_wr_ack) begin
                chk("t3_addr0", 128'(app_addr), 128'(exp_addr(0, s0)));
                ids[n] = 0; n++; s0++;
            end
            if (la1_wr_ack && n < 64) begin
                chk("t3_addr1", 128'(app_addr), 128'(exp_addr(1, s1)));
                ids[n] = 1; n++; s1++;
            end
            tick();
        end
        chk("t3_total", 128'(n), 128'(64));
        for (int r = 0; r < 4; r++) begin
            cnt = 0;
            for (int k = 0; k < 16; k++) if (ids[16 * r + k] == r % 2) cnt++;
            chk($sformatf("t3_run%0d", r), 128'(cnt), 128'(16));
        end
        d = (s0 > s1) ? s0 - s1 : s1 - s0;
        chk("t3_fair", 128'(d <= 16), 128'(1));

        // Command accepted first, data stalled 5 cycles
        rst_all();
        lim0 = 1; drive(); app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        settle();
        chk("t4_idle_en", 128'(app_en), 128'(0));
        tick();
        cmd_n = 0; dat_n = 0; en_n = 0;
        for (int g = 0; g < 6; g++) begin
            app_wdf_rdy = (g == 5);
            settle();
            if (app_en) en_n++;
            if (app_en && app_rdy) cmd_n++;
            if (app_wdf_wren && app_wdf_rdy) dat_n++;
            chk($sformatf("t4_ack_g%0d", g), 128'(la0_wr_ack), 128'(g == 5));
            tick();
        end
        chk("t4_en_cycles", 128'(en_n), 128'(1));
        chk("t4_cmds", 128'(cmd_n), 128'(1));
        chk("t4_data", 128'(dat_n), 128'(1));
        s0 = 1; drive(); settle();
        chk("t4_busy_release_cyc", 128'(busy), 128'(1));
        tick(); settle();
        chk("t4_busy_after", 128'(busy), 128'(0));

        // Data accepted first; wr_en dropped while the beat is half-issued
        rst_all();
        lim0 = 1; drive(); app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        tick(); settle();
        chk("t5_wren_g0", 128'(app_wdf_wren), 128'(1));
        chk("t5_ack_g0", 128'(la0_wr_ack), 128'(0));
        tick();
        la0_wr_en = 1'b0; settle();
        chk("t5_wren_g1", 128'(app_wdf_wren), 128'(0));
        chk("t5_en_g1", 128'(app_en), 128'(1));
        chk("t5_ack_g1", 128'(la0_wr_ack), 128'(0));
        tick(); settle();
        chk("t5_busy_g2", 128'(busy), 128'(1));
        tick();
        app_rdy = 1'b1; settle();
        chk("t5_ack_g3", 128'(la0_wr_ack), 128'(1));
        tick();
        la0_wr_valid = 1'b0; settle();
        chk("t5_idle", 128'(busy), 128'(0));

        // Reset while a command half is outstanding restores last_grant=1
        rst_all();
        lim0 = 1; drive(); app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        tick(); settle();
        chk("t6_pre_ack", 128'(la0_wr_ack), 128'(1));
        tick();
        s0 = 1; drive(); tick();
        lim1 = 1; drive(); app_wdf_rdy = 1'b0;
        tick(); settle();
        chk("t6_grant1", 128'(grant_id), 128'(1));
        chk("t6_cmd_g0", 128'(app_en), 128'(1));
        tick(); settle();
        chk("t6_cmd_done", 128'(app_en), 128'(0));
        rst = 1'b1; s0 = 0; drive();
        tick(); settle();
        chk("t6_rst_en", 128'(app_en), 128'(0));
        chk("t6_rst_wren", 128'(app_wdf_wren), 128'(0));
        chk("t6_rst_ack1", 128'(la1_wr_ack), 128'(0));
        chk("t6_rst_busy", 128'(busy), 128'(0));
        chk("t6_rst_grant", 128'(grant_id), 128'(0));
        rst = 1'b0;
        tick(); settle();
        chk("t6_tie_grant", 128'(grant_id), 128'(0));
        chk("t6_tie_busy", 128'(busy), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
